psum_buffer_ctrl: RTL and testbench

//  Partial-sum buffer and write-back stage directly downstream of the main controller.

---
 rtl/psum_pkg.sv | 18 +
 rtl/psum_buffer_ctrl_if.sv | 13 +
 rtl/psum_regfile.sv | 43 ++++
 rtl/psum_buffer_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_psum_buffer_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types for the partial-sum buffer: FSM state encoding and stall codes
// returned to the main controller.
package psum_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        ACC  = 3'd2,
        WB   = 3'd3,
        PUSH = 3'd4,
        RESP = 3'd5
    } psum_state_e;

    localparam logic [1:0] STALL_BUSY = 2'b00;
    localparam logic [1:0] STALL_NEXT = 2'b10;
    localparam logic [1:0] STALL_DONE = 2'b11;

endpackage

// File: rtl/psum_buffer_ctrl_if.sv
// Final-sum output stream (valid/ready) between the psum buffer and the
// downstream consumer.
interface psum_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/psum_regfile.sv
// DEPTH x DATA_WIDTH psum storage: one write port, one registered read port,
// with a same-cycle write to the read address forwarded into the read data.
module psum_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // storage array has no reset so contents survive global clears
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // registered read with write-first forwarding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (i_we && (i_waddr == i_raddr)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/psum_buffer_ctrl.sv
// Partial-sum buffer and write-back stage: stores, accumulates and streams psums.
// Define PSUM_SATURATE_EN to make accumulation a signed saturating add.
module psum_buffer_ctrl
    import psum_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_global_rst,
    input  logic                  i_chip_en,
    input  logic [DATA_WIDTH-1:0] i_result_in,
    input  logic                  i_first_time,
    input  logic                  i_next_psum_waddr,
    input  logic                  i_next_psum_raddr,
    input  logic                  i_rst_psum_raddr,
    input  logic                  i_psum_buffer_ren,
    input  logic                  i_done,
    input  logic                  i_last_pass,
    output logic                  o_psum_buffer_valid,
    output logic [DATA_WIDTH-1:0] o_psum_rdata,
    output logic                  o_can_read_psum,
    output logic                  o_psum_w_co,
    output logic [1:0]            o_stall,
    output logic [ADDR_WIDTH:0]   o_psum_count,
    psum_buffer_ctrl_if.master    psum_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] psum_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
`ifdef PSUM_SATURATE_EN
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            psum_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            psum_add = s[DATA_WIDTH-1:0];
        end
`else
        psum_add = a + b;
`endif
    endfunction

    psum_state_e             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;
    logic [ADDR_WIDTH:0]     r_count, w_count_nxt;
    logic                    r_last_pass, r_out_valid, r_psum_buffer_valid;
    logic                    r_can_read, r_w_co;
    logic [1:0]              r_stall, w_stall_nxt;
    logic [DATA_WIDTH-1:0]   r_sum, w_rdata, w_wr_data;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic                    w_we, w_ren_ok, w_rf_we, w_rf_re, w_active;

    assign w_active = i_chip_en & ~i_global_rst;
    assign w_ren_ok = i_psum_buffer_ren & r_can_read;
    assign w_rf_we  = w_we & w_active;
    assign w_rf_re  = w_active & ((r_state == RD) | w_ren_ok);

    psum_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_rf_we),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wr_data),
        .i_re    (w_rf_re),
        .i_raddr (r_raddr),
        .o_rdata (w_rdata)
    );

    // next address/count values; count saturates while waddr wraps
    always_comb begin
        w_waddr_nxt = r_waddr;
        w_count_nxt = r_count;
        w_raddr_nxt = r_raddr;
        if (i_next_psum_waddr) begin
            w_waddr_nxt = r_waddr + ADDR_WIDTH'(1);
            if (r_count != DEPTH_CNT) begin
                w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
            end else begin
                w_count_nxt = r_count;
            end
        end else begin
            w_waddr_nxt = r_waddr;
        end
        if (i_rst_psum_raddr) begin
            w_raddr_nxt = '0;
        end else if (i_next_psum_raddr) begin
            w_raddr_nxt = r_raddr + ADDR_WIDTH'(1);
        end else begin
            w_raddr_nxt = r_raddr;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (i_global_rst) begin
            r_state <= IDLE;
        end else if (i_chip_en) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; done outside IDLE is ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_done) w_state_nxt = RD; else w_state_nxt = IDLE;
            RD:      w_state_nxt = ACC;
            ACC:     if (r_last_pass) w_state_nxt = PUSH; else w_state_nxt = WB;
            WB:      w_state_nxt = RESP;
            PUSH:    if (psum_out.out_ready) w_state_nxt = RESP; else w_state_nxt = PUSH;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall code for the RESP cycle and write-port arbitration
    always_comb begin
        w_stall_nxt = STALL_BUSY;
        w_we        = 1'b0;
        w_wr_addr   = r_waddr;
        w_wr_data   = i_result_in;
        if (w_state_nxt == RESP) begin
            if (r_last_pass && ({1'b0, r_raddr} == (r_count - (ADDR_WIDTH+1)'(1)))) begin
                w_stall_nxt = STALL_DONE;
            end else begin
                w_stall_nxt = STALL_NEXT;
            end
        end else begin
            w_stall_nxt = STALL_BUSY;
        end
        // write-back of an in-flight entry wins over a new first-time write
        if (r_state == WB) begin
            w_we      = 1'b1;
            w_wr_addr = r_raddr;
            w_wr_data = r_sum;
        end else if (i_first_time) begin
            w_we      = 1'b1;
            w_wr_addr = r_waddr;
            w_wr_data = i_result_in;
        end else begin
            w_we      = 1'b0;
        end
    end

    // counters, captured pass flag, sum and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr <= '0; r_raddr <= '0; r_count <= '0;
            r_can_read <= 1'b0; r_w_co <= 1'b0; r_psum_buffer_valid <= 1'b0;
            r_stall <= STALL_BUSY; r_out_valid <= 1'b0; r_last_pass <= 1'b0; r_sum <= '0;
        end else if (i_global_rst) begin
            r_waddr <= '0; r_raddr <= '0; r_count <= '0;
            r_can_read <= 1'b0; r_w_co <= 1'b0; r_psum_buffer_valid <= 1'b0;
            r_stall <= STALL_BUSY; r_out_valid <= 1'b0; r_last_pass <= 1'b0; r_sum <= '0;
        end else if (i_chip_en) begin
            r_waddr             <= w_waddr_nxt;
            r_raddr             <= w_raddr_nxt;
            r_count             <= w_count_nxt;
            r_can_read          <= ({1'b0, w_raddr_nxt} < w_count_nxt);
            r_w_co              <= (w_waddr_nxt == ADDR_LAST);
            r_psum_buffer_valid <= w_ren_ok;
            r_stall             <= w_stall_nxt;
            r_out_valid         <= (w_state_nxt == PUSH);
            if ((r_state == IDLE) && i_done) begin
                r_last_pass <= i_last_pass;
            end
            if (r_state == ACC) begin
                r_sum <= psum_add(w_rdata, i_result_in);
            end
        end
    end

    assign o_psum_buffer_valid = r_psum_buffer_valid;
    assign o_psum_rdata        = w_rdata;
    assign o_can_read_psum     = r_can_read;
    assign o_psum_w_co         = r_w_co;
    assign o_stall             = r_stall;
    assign o_psum_count        = r_count;
    assign psum_out.out_data   = r_sum;
    assign psum_out.out_valid  = r_out_valid;

endmodule

// File: tb/tb_psum_buffer_ctrl.sv
// Self-checking bench for psum_buffer_ctrl against a transaction-level model
// (array memory, integer pointers, integer arithmetic for the accumulate).
module tb_psum_buffer_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset, i_global_rst, i_chip_en, i_first_time, i_next_psum_waddr;
    logic i_next_psum_raddr, i_rst_psum_raddr, i_psum_buffer_ren, i_done, i_last_pass;
    logic [DW-1:0] i_result_in;
    logic o_psum_buffer_valid, o_can_read_psum, o_psum_w_co;
    logic [DW-1:0] o_psum_rdata;
    logic [1:0] o_stall;
    logic [AW:0] o_psum_count;

    psum_buffer_ctrl_if #(.DATA_WIDTH(DW)) out_if ();

    psum_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .i_global_rst(i_global_rst), .i_chip_en(i_chip_en),
        .i_result_in(i_result_in), .i_first_time(i_first_time),
        .i_next_psum_waddr(i_next_psum_waddr), .i_next_psum_raddr(i_next_psum_raddr),
        .i_rst_psum_raddr(i_rst_psum_raddr), .i_psum_buffer_ren(i_psum_buffer_ren),
        .i_done(i_done), .i_last_pass(i_last_pass),
        .o_psum_buffer_valid(o_psum_buffer_valid), .o_psum_rdata(o_psum_rdata),
        .o_can_read_psum(o_can_read_psum), .o_psum_w_co(o_psum_w_co),
        .o_stall(o_stall), .o_psum_count(o_psum_count), .psum_out(out_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int m_waddr, m_raddr, m_count;

    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return DW'(s);
    endfunction

    function automatic logic [1:0] model_code(input logic lp);
        return (lp && (m_raddr == m_count - 1)) ? 2'b11 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [DW-1:0] v);
        i_first_time = 1'b1; i_next_psum_waddr = 1'b1; i_result_in = v;
        tick();
        i_first_time = 1'b0; i_next_psum_waddr = 1'b0;
        m_mem[m_waddr] = v;
        m_waddr = (m_waddr + 1) % DEPTH;
        if (m_count < DEPTH) m_count++;
    endtask

    task automatic do_glob();
        i_global_rst = 1'b1; tick(); i_global_rst = 1'b0;
        m_waddr = 0; m_raddr = 0; m_count = 0;
    endtask

    task automatic do_next_raddr();
        i_next_psum_raddr = 1'b1; tick(); i_next_psum_raddr = 1'b0;
        m_raddr = (m_raddr + 1) % DEPTH;
    endtask

    task automatic do_rst_raddr();
        i_rst_psum_raddr = 1'b1; i_next_psum_raddr = 1'b1; tick();
        i_rst_psum_raddr = 1'b0; i_next_psum_raddr = 1'b0;
        m_raddr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({o_psum_buffer_valid, out_if.out_valid, out_if.out_data, o_stall, o_can_read_psum,
             o_psum_w_co, o_psum_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ov=%b od=%h stall=%b can=%b co=%b cnt=%0d expected all 0",
                     o_psum_buffer_valid, out_if.out_valid, out_if.out_data, o_stall,
                     o_can_read_psum, o_psum_w_co, o_psum_count);
        end
        reset = 1'b0;
        m_waddr = 0; m_raddr = 0; m_count = 0;
        tick();
        for (int i = 0; i < 3; i++) do_write(DW'($urandom));
        do_next_raddr();
        do_glob();
        checks++;
        if ({o_psum_buffer_valid, out_if.out_valid, o_stall, o_can_read_psum, o_psum_w_co,
             o_psum_count} !== '0) begin
            errors++;
            $display("FAIL global_rst_outputs: got valid=%b ov=%b stall=%b can=%b co=%b cnt=%0d expected all 0",
                     o_psum_buffer_valid, out_if.out_valid, o_stall, o_can_read_psum,
                     o_psum_w_co, o_psum_count);
        end
        // count an entry without writing: the old contents must still be there
        i_next_psum_waddr = 1'b1; tick(); i_next_psum_waddr = 1'b0;
        m_waddr = 1; m_count = 1;
        i_psum_buffer_ren = 1'b1; tick(); i_psum_buffer_ren = 1'b0;
        checks++;
        if (o_psum_buffer_valid !== 1'b1 || o_psum_rdata !== m_mem[0]) begin
            errors++;
            $display("FAIL mem_kept: got valid=%b data=%h expected 1 %h", o_psum_buffer_valid, o_psum_rdata, m_mem[0]);
        end
    endtask

    task automatic test_write_read();
        logic exp_v;
        do_glob();
        do_write(16'd5); do_write(16'd7); do_write(16'd9);
        checks++;
        if (o_psum_count !== (AW+1)'(m_count)) begin
            errors++; $display("FAIL count3: got %0d expected %0d", o_psum_count, m_count);
        end
        do_next_raddr();
        for (int it = 0; it < 10; it++) begin
            if (it > 0) begin
                if ($urandom_range(3, 0) == 0) do_rst_raddr(); else do_next_raddr();
            end
            exp_v = (m_raddr < m_count);
            checks++;
            if (o_can_read_psum !== exp_v) begin
                errors++; $display("FAIL can_read: raddr=%0d got %b expected %b", m_raddr, o_can_read_psum, exp_v);
            end
            i_psum_buffer_ren = 1'b1; tick(); i_psum_buffer_ren = 1'b0;
            checks++;
            if (o_psum_buffer_valid !== exp_v || (exp_v && o_psum_rdata !== m_mem[m_raddr])) begin
                errors++;
                $display("FAIL read: raddr=%0d got valid=%b data=%h expected valid=%b data=%h",
                         m_raddr, o_psum_buffer_valid, o_psum_rdata, exp_v, m_mem[m_raddr]);
            end
            tick();
            checks++;
            if (o_psum_buffer_valid !== 1'b0) begin
                errors++; $display("FAIL read_pulse: got %b expected 0", o_psum_buffer_valid);
            end
        end
    endtask

    task automatic test_acc_wb();
        logic [DW-1:0] r, exp_sum;
        logic [1:0] exp_st;
        int n;
        for (int it = 0; it < 5; it++) begin
            do_glob();
            if (it == 0) begin
                do_write(16'd5); r = 16'd3;
            end else begin
                n = $urandom_range(6, 1);
                for (int j = 0; j < n; j++) do_write(DW'($urandom));
                repeat ($urandom_range(n - 1, 0)) do_next_raddr();
                r = DW'($urandom);
            end
            exp_sum = model_add(m_mem[m_raddr], r);
            i_result_in = r; i_last_pass = 1'b0; i_done = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (k == 3) i_done = 1'b0;
                exp_st = (k == 4) ? model_code(1'b0) : 2'b00;
                checks++;
                if (o_stall !== exp_st) begin
                    errors++; $display("FAIL wb_stall it=%0d k=%0d: got %b expected %b", it, k, o_stall, exp_st);
                end
            end
            m_mem[m_raddr] = exp_sum;
            i_psum_buffer_ren = 1'b1; tick(); i_psum_buffer_ren = 1'b0;
            checks++;
            if (o_psum_buffer_valid !== 1'b1 || o_psum_rdata !== exp_sum) begin
                errors++;
                $display("FAIL wb_data it=%0d: got valid=%b data=%h expected 1 %h", it, o_psum_buffer_valid, o_psum_rdata, exp_sum);
            end
        end
    endtask

    task automatic test_push();
        logic [DW-1:0] r, exp_sum;
        logic [1:0] exp_st;
        int n, w;
        for (int it = 0; it < 5; it++) begin
            do_glob();
            if (it == 0) begin
                do_write(16'd5); r = 16'd2; w = 3;
            end else begin
                n = $urandom_range(5, 1);
                for (int j = 0; j < n; j++) do_write(DW'($urandom));
                repeat ($urandom_range(n - 1, 0)) do_next_raddr();
                r = DW'($urandom); w = $urandom_range(4, 0);
            end
            exp_sum = model_add(m_mem[m_raddr], r);
            exp_st = model_code(1'b1);
            i_result_in = r; i_last_pass = 1'b1; out_if.out_ready = 1'b0; i_done = 1'b1;
            tick(); i_done = 1'b0;
            tick(); tick();
            for (int k = 0; k <= w; k++) begin
                if (k > 0) tick();
                checks++;
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_sum || o_stall !== 2'b00) begin
                    errors++;
                    $display("FAIL push_hold it=%0d k=%0d: got ov=%b od=%h stall=%b expected 1 %h 00",
                             it, k, out_if.out_valid, out_if.out_data, o_stall, exp_sum);
                end
            end
            out_if.out_ready = 1'b1; tick(); out_if.out_ready = 1'b0;
            checks++;
            if (out_if.out_valid !== 1'b0 || o_stall !== exp_st) begin
                errors++;
                $display("FAIL push_resp it=%0d: got ov=%b stall=%b expected 0 %b", it, out_if.out_valid, o_stall, exp_st);
            end
            tick();
            checks++;
            if (o_stall !== 2'b00) begin
                errors++; $display("FAIL push_idle it=%0d: got stall=%b expected 00", it, o_stall);
            end
        end
    endtask

    task automatic test_chip_en_and_async_reset();
        do_glob();
        do_write(16'd40);
        i_result_in = 16'd2; i_last_pass = 1'b1; out_if.out_ready = 1'b0; i_done = 1'b1;
        tick(); i_done = 1'b0;
        tick(); tick();
        // frozen: handshake and counter requests have no effect
        i_chip_en = 1'b0; out_if.out_ready = 1'b1; i_next_psum_waddr = 1'b1;
        tick(); tick();
        i_next_psum_waddr = 1'b0;
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'd42 || o_psum_count !== (AW+1)'(m_count)) begin
            errors++;
            $display("FAIL chip_en_freeze: got ov=%b od=%h cnt=%0d expected 1 002a %0d",
                     out_if.out_valid, out_if.out_data, o_psum_count, m_count);
        end
        i_chip_en = 1'b1; tick(); out_if.out_ready = 1'b0;
        checks++;
        if (out_if.out_valid !== 1'b0 || o_stall !== 2'b11) begin
            errors++; $display("FAIL chip_en_resume: got ov=%b stall=%b expected 0 11", out_if.out_valid, o_stall);
        end
        tick();
        i_done = 1'b1; tick(); i_done = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #2;
        checks++;
        if (out_if.out_valid !== 1'b0 || o_psum_count !== '0) begin
            errors++; $display("FAIL async_reset_push: got ov=%b cnt=%0d expected 0 0", out_if.out_valid, o_psum_count);
        end
        reset = 1'b0;
        m_waddr = 0; m_raddr = 0; m_count = 0;
        tick();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] v;
        do_glob();
        for (int i = 0; i < 17; i++) begin
            do_write(DW'($urandom));
            checks++;
            if (o_psum_w_co !== (m_waddr == DEPTH - 1) || o_psum_count !== (AW+1)'(m_count)) begin
                errors++;
                $display("FAIL wrap i=%0d: got co=%b cnt=%0d expected %b %0d",
                         i, o_psum_w_co, o_psum_count, (m_waddr == DEPTH - 1), m_count);
            end
        end
        do_rst_raddr(); do_next_raddr();
        v = DW'($urandom);
        i_psum_buffer_ren = 1'b1; i_first_time = 1'b1; i_result_in = v;
        tick();
        i_psum_buffer_ren = 1'b0; i_first_time = 1'b0;
        m_mem[m_waddr] = v;
        checks++;
        if (o_psum_buffer_valid !== 1'b1 || o_psum_rdata !== v) begin
            errors++; $display("FAIL bypass: got valid=%b data=%h expected 1 %h", o_psum_buffer_valid, o_psum_rdata, v);
        end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] exp_c;
`ifdef PSUM_SATURATE_EN
        exp_c = 16'h7FFF;
`else
        exp_c = 16'h8000;
`endif
        do_glob();
        do_write(16'h7FFF);
        i_result_in = 16'h0001; i_last_pass = 1'b1; out_if.out_ready = 1'b1; i_done = 1'b1;
        tick(); i_done = 1'b0;
        tick(); tick();
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_c || out_if.out_data !== model_add(16'h7FFF, 16'h0001)) begin
            errors++; $display("FAIL sat_push: got ov=%b od=%h expected 1 %h", out_if.out_valid, out_if.out_data, exp_c);
        end
        tick(); tick(); out_if.out_ready = 1'b0;
        do_glob();
        do_write(16'h8000);
        i_result_in = 16'hFFFF; i_last_pass = 1'b0; i_done = 1'b1;
        tick(); i_done = 1'b0;
        repeat (5) tick();
        i_psum_buffer_ren = 1'b1; tick(); i_psum_buffer_ren = 1'b0;
        checks++;
        if (o_psum_rdata !== model_add(16'h8000, 16'hFFFF)) begin
            errors++; $display("FAIL sat_wb: got %h expected %h", o_psum_rdata, model_add(16'h8000, 16'hFFFF));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; i_global_rst = 1'b0; i_chip_en = 1'b1; i_first_time = 1'b0;
        i_next_psum_waddr = 1'b0; i_next_psum_raddr = 1'b0; i_rst_psum_raddr = 1'b0;
        i_psum_buffer_ren = 1'b0; i_done = 1'b0; i_last_pass = 1'b0; i_result_in = '0;
        out_if.out_ready = 1'b0;
        test_reset();
        test_write_read();
        test_acc_wb();
        test_push();
        test_chip_en_and_async_reset();
        test_wrap();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
